ps2_letter_decoder: RTL and testbench
=====================================

# ps2_letter_decoder

Keyboard-side front end of the Enigma machine. Receives PS/2 scan-code set 2 frames from the board's PS/2 port and produces the 26-bit one-hot letter vector that the cipher path and the VGA lampboard/wheel display consume. The output uses bit 0 = A through bit 25 = Z. It also emits a single-cycle strobe per new keypress, so rotors step once per press and not on typematic repeat.

## Interface
Parameters:
- TIMEOUT_CYCLES, 50000: maximum CLOCK_50 cycles between PS/2 clock falling edges inside a frame before the frame is aborted (1 ms at 50 MHz).
- SYNC_STAGES, 2: flip-flop depth of the synchronisers on PS2_CLK and PS2_DAT.

Ports:
- CLOCK_50  in  1: system clock, 50 MHz. This is the block's only clock.
- reset  in  1: synchronous reset, active-high.
- PS2_CLK  in  1: keyboard clock. Asynchronous; synchronised internally.
- PS2_DAT  in  1: keyboard data. Asynchronous; synchronised internally.
- letter  out  26: one-hot currently-held letter. All zeros when no letter is held.
- letter_strobe  out  1: 1-cycle pulse when `letter` takes a new non-zero value.
- frame_err  out  1: 1-cycle pulse on a discarded frame (start, parity, stop, or timeout fault).

## Operation
Frame receiver FSM (states IDLE, DATA, PARITY, STOP):
- Sampling: PS2_DAT is sampled on each synchronised PS2_CLK falling edge.
- IDLE:
  - sample 0 (start bit) → DATA, bit counter = 0;
  - sample 1 → stay in IDLE and pulse frame_err.
- DATA: shift the 8 data bits in LSB first; after the 8th bit → PARITY.
- PARITY: capture the parity bit → STOP.
- STOP: the frame is valid when the stop bit is 1 and the data bits plus parity bit contain an odd number of ones.
  - Valid frame: issue a 1-cycle code_valid with an 8-bit code.
  - Invalid frame: pulse frame_err.
  - Either way → IDLE.
- Timeout: the edge-gap counter resets on every falling edge. If it reaches TIMEOUT_CYCLES in any state other than IDLE → IDLE, frame_err pulse, partial data discarded.

Decoder, acting on code_valid; state flags are brk_pend and ext_pend:
- 0xE0: set ext_pend.
- 0xF0: set brk_pend.
- Any other code with ext_pend set: ignored (covers E0 xx and E0 F0 xx). Clear both flags.
- Letter make code (brk_pend clear):
  - If it differs from the held letter, load the one-hot into `letter` and pulse letter_strobe.
  - If it equals the held letter (typematic repeat), no change and no strobe.
- Letter break code (brk_pend set):
  - If it matches the held letter, letter = 0, no strobe.
  - Otherwise `letter` is unchanged.
  - Clear brk_pend.
- Non-letter codes: `letter` unchanged; clear both flags.
- Scan-code map, hex, A..Z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
- frame_err: also clears brk_pend and ext_pend.

## Timing
- Reset values: letter = 0, letter_strobe = 0, frame_err = 0, FSM in IDLE, all flags and counters 0.
- Reset mid-frame: the partial frame is dropped. The first clean start bit after reset deasserts is accepted.
- Edge detection: edge_fall is asserted SYNC_STAGES+1 cycles after the pin falls.
- Bit capture: the bit is captured in the edge_fall cycle.
- Latency: code_valid is registered 1 cycle after the stop-bit edge_fall. `letter` and letter_strobe are registered 1 cycle after that, so 2 cycles after the stop-bit edge_fall.
- Pulse widths: letter_strobe and frame_err are exactly 1 CLOCK_50 cycle.
- Simultaneous timeout and edge in the same cycle: the edge wins.
- Simultaneous reset and anything: reset wins.
- Decoder capacity: at most one code_valid every 11 PS/2 bit periods, so the decoder needs no buffering.

## Structure
- Package enigma_pkg holds:
  - the 26 set-2 scan-code constants;
  - SC_BREAK = 8'hF0 and SC_EXT = 8'hE0;
  - a function scan_to_index returning {hit, 5-bit index}.
  - The lampboard and wheel code reuse the letter-index order defined here.
- Sub-module ps2_frame_rx contains:
  - the synchronisers, falling-edge detect, FSM, shift register, parity check and timeout counter;
  - outputs code[7:0], code_valid and frame_err.
- The top level ps2_letter_decoder holds the make/break/extended logic and the output registers.

## Test plan
- Make A: frame 0x1C, parity bit 0, stop 1 → letter = 26'h1 and one letter_strobe, 2 cycles after the stop edge. Then F0, 1C → letter = 0, no further strobe.
- Typematic: 1C, 1C, 1C → exactly one strobe; letter stays 26'h1.
- Rollover: while A is held, send 1A → letter = 26'h2000000 with a strobe. Then F0 1C → letter unchanged. Then F0 1A → letter = 0.
- Extended: E0 75, E0 F0 75, E0 1C → letter stays 0, no strobe, no frame_err. A following 15 → letter = 26'h10000.
- Parity fault: 0x1C sent with parity 1 → frame_err pulse, letter unchanged. A stop bit of 0 → frame_err as well.
- Timeout and reset:
  - Stop PS2_CLK after 4 data bits → frame_err exactly TIMEOUT_CYCLES after the last edge. A subsequent full 0x2C frame → letter = 26'h80000.
  - Assert reset mid-frame → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared definitions for the Enigma keyboard front end.
//   - PS/2 scan-code set 2 make codes for A..Z, plus the break and
//     extended prefixes.
//   - Frame receiver state encoding.
//   - scan_to_index(): maps a make code to {hit, letter index}. Index 0 is A
//     and index 25 is Z. The lampboard and wheel display use the same order.
package enigma_pkg;

    localparam int NUM_LETTERS = 26;

    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_B = 8'h32;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43;
    localparam logic [7:0] SC_J = 8'h3B;
    localparam logic [7:0] SC_K = 8'h42;
    localparam logic [7:0] SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A;
    localparam logic [7:0] SC_N = 8'h31;
    localparam logic [7:0] SC_O = 8'h44;
    localparam logic [7:0] SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C;
    localparam logic [7:0] SC_V = 8'h2A;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35;
    localparam logic [7:0] SC_Z = 8'h1A;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } scan_hit_t;

    function automatic scan_hit_t scan_to_index(input logic [7:0] code);
        scan_hit_t r;
        r.hit = 1'b1;
        r.idx = 5'd0;
        case (code)
            SC_A: r.idx = 5'd0;
            SC_B: r.idx = 5'd1;
            SC_C: r.idx = 5'd2;
            SC_D: r.idx = 5'd3;
            SC_E: r.idx = 5'd4;
            SC_F: r.idx = 5'd5;
            SC_G: r.idx = 5'd6;
            SC_H: r.idx = 5'd7;
            SC_I: r.idx = 5'd8;
            SC_J: r.idx = 5'd9;
            SC_K: r.idx = 5'd10;
            SC_L: r.idx = 5'd11;
            SC_M: r.idx = 5'd12;
            SC_N: r.idx = 5'd13;
            SC_O: r.idx = 5'd14;
            SC_P: r.idx = 5'd15;
            SC_Q: r.idx = 5'd16;
            SC_R: r.idx = 5'd17;
            SC_S: r.idx = 5'd18;
            SC_T: r.idx = 5'd19;
            SC_U: r.idx = 5'd20;
            SC_V: r.idx = 5'd21;
            SC_W: r.idx = 5'd22;
            SC_X: r.idx = 5'd23;
            SC_Y: r.idx = 5'd24;
            SC_Z: r.idx = 5'd25;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver.
// This module synchronises the PS/2 clock and data lines, detects falling
// edges of the PS/2 clock, and shifts in 11-bit frames. Each frame has a
// start bit, 8 data bits sent LSB first, an odd-parity bit and a stop bit.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   ps2_clk    in   raw keyboard clock (asynchronous)
//   ps2_dat    in   raw keyboard data (asynchronous)
//   code       out  last good scan code (valid while code_valid is high)
//   code_valid out  1-cycle pulse, one cycle after the stop-bit edge
//   frame_err  out  1-cycle pulse for a start, parity, stop or timeout fault
// SYNC_STAGES must be >= 2. TIMEOUT_CYCLES must be >= 2.
module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);
    import enigma_pkg::*;

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    // The gap counter holds k in the k-th cycle after an edge. The timeout
    // fires when the counter is at TIMEOUT_CYCLES-1. Because frame_err is
    // registered, it is then seen exactly TIMEOUT_CYCLES cycles after the
    // edge_fall cycle.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_prev;
    logic                   edge_fall;
    logic                   dat_bit;

    // The synchronisers are left free-running through reset. After reset,
    // clk_prev then tracks the real pin level, so a keyboard clock that is
    // held low across reset does not look like a fresh falling edge.
    always_ff @(posedge clk) begin
        clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
        dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
        clk_prev <= clk_sync[SYNC_STAGES-1];
        dat_bit  <= dat_sync[SYNC_STAGES-1];
    end

    // edge_fall is registered, so it is seen SYNC_STAGES+1 cycles after the
    // pin falls. dat_bit is registered in the same way, so it lines up with
    // edge_fall.
    always_ff @(posedge clk) begin
        if (reset) edge_fall <= 1'b0;
        else       edge_fall <= clk_prev & ~clk_sync[SYNC_STAGES-1];
    end

    rx_state_t        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       code_q, code_d;
    logic             code_valid_q, code_valid_d;
    logic             frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            gap_q        <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            gap_q        <= gap_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        gap_d        = (state_q == IDLE) ? '0 : gap_q + 1'b1;

        if (edge_fall) begin
            // An edge always wins over a timeout in the same cycle.
            gap_d = GAP_W'(1);
            case (state_q)
                IDLE: begin
                    if (!dat_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d   = {dat_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_bit;
                    state_d = STOP;
                end
                STOP: begin
                    if (dat_bit && (^{shift_q, par_q})) begin
                        code_valid_d = 1'b1;
                        code_d       = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && gap_q == GAP_LAST) begin
            state_d     = IDLE;
            gap_d       = '0;
            frame_err_d = 1'b1;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_letter_decoder.sv
// ps2_letter_decoder: keyboard front end for the Enigma machine.
// This block turns PS/2 set-2 make/break/extended sequences into a one-hot
// "held letter" vector (bit 0 = A .. bit 25 = Z). It also gives a 1-cycle
// strobe for each new keypress, so typematic repeats never step the rotors.
// Ports:
//   CLOCK_50      in   50 MHz system clock
//   reset         in   synchronous, active-high
//   PS2_CLK       in   keyboard clock (asynchronous)
//   PS2_DAT       in   keyboard data (asynchronous)
//   letter        out  one-hot held letter, zero when none is held
//   letter_strobe out  1-cycle pulse when letter takes a new non-zero value
//   frame_err     out  1-cycle pulse when a frame is discarded
module ps2_letter_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [25:0] letter,
    output logic        letter_strobe,
    output logic        frame_err
);
    import enigma_pkg::*;

    logic [7:0] code;
    logic       code_valid;
    logic       rx_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk       (CLOCK_50),
        .reset     (reset),
        .ps2_clk   (PS2_CLK),
        .ps2_dat   (PS2_DAT),
        .code      (code),
        .code_valid(code_valid),
        .frame_err (rx_err)
    );

    scan_hit_t                hit;
    logic [NUM_LETTERS-1:0]   onehot;
    logic [NUM_LETTERS-1:0]   letter_d;
    logic                     strobe_d;
    logic                     brk_pend, brk_d;
    logic                     ext_pend, ext_d;

    assign hit    = scan_to_index(code);
    assign onehot = NUM_LETTERS'(1) << hit.idx;

    always_comb begin
        letter_d = letter;
        strobe_d = 1'b0;
        brk_d    = brk_pend;
        ext_d    = ext_pend;

        if (rx_err) begin
            // A lost frame may have been the second half of a prefix pair,
            // so the pending prefixes can no longer be trusted.
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (code_valid) begin
            if (code == SC_EXT) begin
                ext_d = 1'b1;
            end else if (code == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (ext_pend) begin
                // E0 xx and E0 F0 xx are non-letter keys. Swallow them.
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (hit.hit) begin
                if (brk_pend) begin
                    // Releasing a key other than the held one leaves the
                    // held letter alone (rollover).
                    if (letter == onehot) letter_d = '0;
                    brk_d = 1'b0;
                end else if (letter != onehot) begin
                    letter_d = onehot;
                    strobe_d = 1'b1;
                end
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            letter        <= '0;
            letter_strobe <= 1'b0;
            brk_pend      <= 1'b0;
            ext_pend      <= 1'b0;
        end else begin
            letter        <= letter_d;
            letter_strobe <= strobe_d;
            brk_pend      <= brk_d;
            ext_pend      <= ext_d;
        end
    end

    // The receiver already registers this pulse, so it is passed straight out.
    assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_letter_decoder.sv
module tb_ps2_letter_decoder;

    localparam int TMO  = 300;
    localparam int HALF = 20;
    localparam int GAP  = 60;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        PS2_CLK  = 1'b1;
    logic        PS2_DAT  = 1'b1;
    logic [25:0] letter;
    logic        letter_strobe;
    logic        frame_err;

    int vectors    = 0;
    int miscompares = 0;
    int strobe_cnt = 0;
    int err_cnt    = 0;

    ps2_letter_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .PS2_CLK      (PS2_CLK),
        .PS2_DAT      (PS2_DAT),
        .letter       (letter),
        .letter_strobe(letter_strobe),
        .frame_err    (frame_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Count high cycles of each pulse. A pulse wider than one cycle shows
    // up as an extra count.
    always @(negedge CLOCK_50) begin
        if (letter_strobe) strobe_cnt++;
        if (frame_err)     err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge CLOCK_50);
        PS2_DAT = b;
        repeat (HALF) @(negedge CLOCK_50);
        PS2_CLK = 1'b0;
        repeat (HALF) @(negedge CLOCK_50);
        PS2_CLK = 1'b1;
    endtask

    // Start bit, 8 data bits LSB first, then the parity bit. flip_par sends
    // the wrong parity.
    task automatic frame_body(input logic [7:0] c, input logic flip_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i]);
        ps2_bit((~^c) ^ flip_par);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic flip_par, input logic stop_bit);
        frame_body(c, flip_par);
        ps2_bit(stop_bit);
        @(negedge CLOCK_50);
        PS2_DAT = 1'b1;
        repeat (GAP) @(negedge CLOCK_50);
    endtask

    task automatic send(input logic [7:0] c);
        send_frame(c, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge CLOCK_50);
        chk("rst_letter", 32'(letter), 32'h0);
        chk("rst_strobe", 32'(letter_strobe), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge CLOCK_50);

        // Make A, with exact latency from the stop-bit edge
        frame_body(8'h1C, 1'b0);
        @(negedge CLOCK_50);
        PS2_DAT = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
        PS2_CLK = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        chk("makeA_early_letter", 32'(letter), 32'h0);
        chk("makeA_early_strobe", 32'(letter_strobe), 32'h0);
        @(negedge CLOCK_50);
        chk("makeA_letter", 32'(letter), 32'h1);
        chk("makeA_strobe", 32'(letter_strobe), 32'h1);
        @(negedge CLOCK_50);
        chk("makeA_strobe_width", 32'(letter_strobe), 32'h0);
        repeat (HALF) @(negedge CLOCK_50);
        PS2_CLK = 1'b1;
        repeat (GAP) @(negedge CLOCK_50);

        // Break A
        send(8'hF0);
        send(8'h1C);
        chk("breakA_letter", 32'(letter), 32'h0);
        chk("breakA_strobes", 32'(strobe_cnt), 32'd1);

        // Typematic repeat gives one strobe only
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        chk("typematic_letter", 32'(letter), 32'h1);
        chk("typematic_strobes", 32'(strobe_cnt), 32'd2);

        // Rollover A -> Z
        send(8'h1A);
        chk("roll_Z", 32'(letter), 32'h2000000);
        chk("roll_strobes", 32'(strobe_cnt), 32'd3);
        send(8'hF0);
        send(8'h1C);
        chk("roll_breakA_kept", 32'(letter), 32'h2000000);
        send(8'hF0);
        send(8'h1A);
        chk("roll_breakZ", 32'(letter), 32'h0);

        // Extended codes are ignored
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h1C);
        chk("ext_letter", 32'(letter), 32'h0);
        chk("ext_strobes", 32'(strobe_cnt), 32'd3);
        chk("ext_errs", 32'(err_cnt), 32'd0);
        send(8'h15);
        chk("ext_then_Q", 32'(letter), 32'h10000);
        chk("ext_then_Q_strobes", 32'(strobe_cnt), 32'd4);

        // Parity and stop faults
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("parity_err", 32'(err_cnt), 32'd1);
        chk("parity_letter", 32'(letter), 32'h10000);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("stop_err", 32'(err_cnt), 32'd2);
        chk("stop_letter", 32'(letter), 32'h10000);

        // A sample of 1 in IDLE is a bad start bit
        ps2_bit(1'b1);
        repeat (GAP) @(negedge CLOCK_50);
        chk("start_err", 32'(err_cnt), 32'd3);

        // Timeout after 4 data bits
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge CLOCK_50);
        PS2_DAT = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
        PS2_CLK = 1'b0;
        for (int n = 1; n <= TMO + 4; n++) begin
            @(negedge CLOCK_50);
            if (n == TMO + 2) chk("tmo_early", 32'(frame_err), 32'h0);
            if (n == TMO + 3) chk("tmo_fire", 32'(frame_err), 32'h1);
            if (n == TMO + 4) chk("tmo_width", 32'(frame_err), 32'h0);
        end
        PS2_CLK = 1'b1;
        repeat (GAP) @(negedge CLOCK_50);
        chk("tmo_errs", 32'(err_cnt), 32'd4);
        send(8'h2C);
        chk("tmo_then_T", 32'(letter), 32'h80000);
        chk("tmo_then_T_strobes", 32'(strobe_cnt), 32'd5);

        // Reset in the middle of a frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("midrst_letter", 32'(letter), 32'h0);
        chk("midrst_strobe", 32'(letter_strobe), 32'h0);
        chk("midrst_err", 32'(frame_err), 32'h0);
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (TMO + 50) @(negedge CLOCK_50);
        chk("midrst_no_tmo", 32'(err_cnt), 32'd4);

        // A discarded frame clears a pending break, so 1C then counts as a make
        send(8'hF0);
        send_frame(8'h33, 1'b1, 1'b1);
        chk("brk_clear_err", 32'(err_cnt), 32'd5);
        send(8'h1C);
        chk("brk_clear_make", 32'(letter), 32'h1);
        chk("brk_clear_strobes", 32'(strobe_cnt), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
